// File: rtl/demux_pkg.sv
// Shared definitions for the demux18 serial-to-parallel deserializer.
package demux_pkg;
    localparam int WIDTH_DEF = 8;
    localparam int SEL_W_DEF = 3;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;
endpackage

// File: rtl/demux18_idx.sv
// Wrapping bit-index counter logic: sof forces the current bit to index 0.
module demux18_idx #(
    parameter int WIDTH = 8,
    parameter int SEL_W = $clog2(WIDTH)
) (
    input  logic [SEL_W-1:0] sel,
    input  logic             sof,
    output logic [SEL_W-1:0] idx,
    output logic [SEL_W-1:0] sel_next,
    output logic             last_bit
);
    // WIDTH is a power of two, so the natural SEL_W overflow is the wrap.
    assign idx      = sof ? '0 : sel;
    assign sel_next = idx + 1'b1;
    assign last_bit = (idx == SEL_W'(WIDTH - 1));
endmodule

// File: rtl/demux18_deser.sv
// Serial-to-parallel deserializer: LSB-first bit assembly through a 1:WIDTH
// demux, with a one-word holding stage behind a valid/ready output register.
module demux18_deser
    import demux_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEF,
    localparam int SEL_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             sof,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [SEL_W-1:0] sel,
    output logic             frame_err
);
    state_t            state_reg, state_next;
    logic [SEL_W-1:0]  sel_reg;
    logic [WIDTH-1:0]  asm_reg;
    logic [WIDTH-1:0]  asm_next;
    logic [WIDTH-1:0]  dout_reg;
    logic              dout_valid_reg;
    logic              frame_err_reg;

    logic [SEL_W-1:0]  idx;
    logic [SEL_W-1:0]  sel_next;
    logic              last_bit;
    logic              accept;
    logic              deliver;
    logic              complete;
    logic              out_free;
    logic              load_complete;
    logic              load_held;

    demux18_idx #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) u_idx (
        .sel      (sel_reg),
        .sof      (sof),
        .idx      (idx),
        .sel_next (sel_next),
        .last_bit (last_bit)
    );

    assign accept        = din_valid & din_ready;
    assign deliver       = dout_valid_reg & dout_ready;
    assign complete      = accept & last_bit;
    assign out_free      = ~dout_valid_reg | dout_ready;
    assign load_complete = complete & out_free;
    assign load_held     = (state_reg == FULL) & deliver;

    // 1:WIDTH demux: only the addressed bit takes din, the rest hold.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_demux
        assign asm_next[gi] = (accept && (idx == SEL_W'(gi))) ? din : asm_reg[gi];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= COLLECT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            COLLECT: if (complete && !out_free) state_next = FULL;
            FULL:    if (deliver)               state_next = COLLECT;
            default:                            state_next = COLLECT;
        endcase
    end

    always_comb begin
        din_ready = (state_reg == COLLECT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_reg        <= '0;
            asm_reg        <= '0;
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            frame_err_reg <= accept & sof & (sel_reg != '0);
            if (accept) begin
                sel_reg <= sel_next;
                asm_reg <= asm_next;
            end
            // A completed word parks in asm_reg while FULL until the consumer frees dout.
            if (load_complete) begin
                dout_reg       <= asm_next;
                dout_valid_reg <= 1'b1;
            end else if (load_held) begin
                dout_reg       <= asm_reg;
                dout_valid_reg <= 1'b1;
            end else if (deliver) begin
                dout_valid_reg <= 1'b0;
            end
        end
    end

    assign dout       = dout_reg;
    assign dout_valid = dout_valid_reg;
    assign sel        = sel_reg;
    assign frame_err  = frame_err_reg;
endmodule

// File: tb/tb_demux18_deser.sv
// Self-checking bench for demux18_deser: directed plan steps plus random traffic
// compared against a word-queue reference model.
module tb_demux18_deser;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         din;
    logic         din_valid;
    logic         din_ready;
    logic         sof;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic [2:0]   sel;
    logic         frame_err;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: words owed to the consumer (output reg + held word).
    logic [W-1:0] words[$];
    logic [W-1:0] m_bits;
    logic [W-1:0] m_last;
    int           m_pos;
    logic         m_ferr;
    int           ferr_count;
    int           word_count;

    demux18_deser #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .sof        (sof),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .sel        (sel),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] m_dout();
        return (words.size() > 0) ? words[0] : m_last;
    endfunction

    task automatic check_outputs();
        chk("dout", 32'(dout), 32'(m_dout()));
        chk("dout_valid", 32'(dout_valid), 32'(words.size() > 0));
        chk("sel", 32'(sel), 32'(m_pos));
        chk("frame_err", 32'(frame_err), 32'(m_ferr));
        if (frame_err) ferr_count++;
    endtask

    task automatic do_reset();
        rst = 1'b1; din = 1'b0; din_valid = 1'b0; sof = 1'b0; dout_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        words.delete();
        m_bits = '0; m_last = '0; m_pos = 0; m_ferr = 1'b0;
        check_outputs();
        chk("din_ready_rst", 32'(din_ready), 32'd1);
    endtask

    task automatic step(input logic d, input logic v, input logic s, input logic r);
        logic acc, dlv, comp;
        int   p;
        din = d; din_valid = v; sof = s; dout_ready = r;
        chk("din_ready", 32'(din_ready), 32'(words.size() < 2));
        acc  = v && (words.size() < 2);
        dlv  = r && (words.size() > 0);
        comp = 1'b0;
        @(posedge clk); #1;
        m_ferr = 1'b0;
        if (acc) begin
            p = s ? 0 : m_pos;
            m_ferr = s && (m_pos != 0);
            m_bits[p] = d;
            m_pos = (p + 1) % W;
            comp = (p == W - 1);
        end
        if (dlv) begin
            m_last = words.pop_front();
            word_count++;
            $display("word %0d delivered: %02h", word_count, m_last);
        end
        if (comp) words.push_back(m_bits);
        check_outputs();
    endtask

    task automatic send_byte(input logic [W-1:0] b, input logic first_sof, input logic r);
        for (int i = 0; i < W; i++) step(b[i], 1'b1, first_sof && (i == 0), r);
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [W-1:0] pat;
        ferr_count = 0;
        word_count = 0;

        // 1: single word 0x4D, visible one cycle after the last bit
        do_reset();
        pat = 8'b0100_1101;
        send_byte(pat, 1'b1, 1'b1);
        chk("t1_dout", 32'(dout), 32'h4D);
        chk("t1_valid", 32'(dout_valid), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t1_valid_drop", 32'(dout_valid), 32'd0);
        chk("t1_ferr", 32'(ferr_count), 32'd0);

        // 2: back-to-back words with no bubble
        send_byte(8'hA5, 1'b1, 1'b1);
        chk("t2_dout_a", 32'(dout), 32'hA5);
        send_byte(8'h3C, 1'b0, 1'b1);
        chk("t2_dout_b", 32'(dout), 32'h3C);
        drain();

        // 3: backpressure fills the holding stage
        send_byte(8'h0F, 1'b1, 1'b0);
        send_byte(8'hF0, 1'b0, 1'b0);
        chk("t3_hold", 32'(dout), 32'h0F);
        chk("t3_ready0", 32'(din_ready), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t3_release", 32'(dout), 32'hF0);
        chk("t3_ready1", 32'(din_ready), 32'd1);
        drain();

        // 4: sof truncates a 3-bit partial word
        ferr_count = 0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("t4_sel", 32'(sel), 32'd1);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("t4_dout", 32'(dout), 32'h01);
        chk("t4_ferr_once", 32'(ferr_count), 32'd1);
        drain();

        // 5: reset mid-word discards the partial bits
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
        do_reset();
        chk("t5_sel0", 32'(sel), 32'd0);
        send_byte(8'h81, 1'b1, 1'b1);
        chk("t5_dout", 32'(dout), 32'h81);
        drain();

        // 6: sof on idle cycles is ignored
        ferr_count = 0;
        pat = 8'hC3;
        for (int i = 0; i < W; i++) begin
            step(pat[i], 1'b1, 1'b0, 1'b1);
            step(1'b0, 1'b0, 1'b1, 1'b1);
        end
        chk("t6_dout", 32'(dout), 32'hC3);
        chk("t6_ferr", 32'(ferr_count), 32'd0);
        drain();

        // Random traffic with occasional sof, backpressure and resets
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 1)),
                     $urandom_range(0, 3) != 0,
                     $urandom_range(0, 15) == 0,
                     $urandom_range(0, 9) < 6);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/demux18_deser.md
Name: demux18_deser

Overview:
- Serial-to-parallel deserializer, the receive-side counterpart of the 8:1 bit-select mux path.
- A 3-bit index counter steers each accepted serial bit through a 1:8 demux into an assembly register.
- Completed bytes are handed to a parallel output register with a valid/ready handshake.
- Sits between a serial link front end and byte-wide consumer logic.

Parameters:
- WIDTH, 8: parallel word width; must be a power of two, at least 2.
- SEL_W, 3: index width, equal to clog2(WIDTH); derived, not overridden.

Ports:
- clk  input  1  rising-edge clock (single clock domain)
- rst  input  1  synchronous, active-high reset
- din  input  1  serial data bit
- din_valid  input  1  din is meaningful this cycle
- din_ready  output  1  block can accept a bit this cycle
- sof  input  1  start-of-frame; qualifies the current bit as index 0
- dout  output  WIDTH  assembled parallel word
- dout_valid  output  1  dout holds an unconsumed word
- dout_ready  input  1  consumer accepts dout this cycle
- sel  output  SEL_W  demux index the next accepted bit will occupy
- frame_err  output  1  one-cycle pulse when sof truncates a partial word

Behaviour:
- Reset is synchronous and active-high. On a clk edge with rst=1:
  - sel=0, assembly register=0, dout=0
  - dout_valid=0, frame_err=0, state=COLLECT, din_ready=1
  - A reset mid-word discards the partial word and any held word without emitting it.
- Accept and deliver events:
  - Accept = din_valid & din_ready.
  - Deliver = dout_valid & dout_ready.
- Bit ordering (LSB first):
  - The k-th accepted bit of a word lands at position k.
  - On accept, asm[idx]<=din, where idx=0 if sof else sel. All other asm bits are unchanged.
- Index counter:
  - On accept, sel<=idx+1, wrapping WIDTH-1 -> 0.
  - sel is not modified without an accept.
- sof handling:
  - sof is only sampled on accept; sof with din_valid=0 is ignored.
  - Accept with sof=1 and sel!=0: frame_err=1 next cycle for exactly one cycle. The partial bits are discarded, and the new bit is stored at index 0.
  - Accept with sof=1 and sel=0: normal, no error.
- State machine:
  - COLLECT: din_ready=1.
    - When an accept has idx=WIDTH-1, the word is complete (including the new bit).
    - If the output register is free (dout_valid=0, or Deliver this same cycle): dout<=completed word, dout_valid<=1, stay in COLLECT. Latency: dout_valid rises the cycle after the last bit is accepted.
    - Otherwise: hold the completed word in asm, go to FULL.
  - FULL: din_ready=0 and no bits are accepted.
    - On Deliver: dout<=asm, dout_valid stays 1, go to COLLECT. din_ready returns to 1 the following cycle.
    - sof is ignored while in FULL.
- Output register:
  - dout_valid clears on Deliver only when no new word is loaded in the same cycle.
  - dout is stable while dout_valid=1 and dout_ready=0.
  - dout retains its last value after delivery.
- Throughput: one bit per cycle sustained when dout_ready=1; no bubble at word boundaries.
- Simultaneous events: completion plus Deliver in the same cycle loads the new word with no drop and no duplicate.
- All outputs are registered except din_ready, which decodes from state.

Decomposition:
- Shared package demux_pkg:
  - WIDTH_DEF=8
  - SEL_W_DEF=3
  - state typedef {COLLECT, FULL}
- One natural sub-module: demux18_idx, the wrapping index counter with sof override. It produces idx, next sel and last_bit (idx==WIDTH-1).

Test Plan:
1. Reset, then 8 accepted bits 1,0,1,1,0,0,1,0 (sof on the first), dout_ready=1 -> dout=8'h4D, dout_valid=1 for one cycle, one cycle after the 8th bit; frame_err never asserts.
2. Back-to-back 16 bits forming 0xA5 then 0x3C, with dout_ready=1 -> din_ready stays 1 throughout; dout shows 0xA5 then 0x3C on consecutive word boundaries.
3. dout_ready=0, send 16 bits (0x0F, 0xF0) -> after word 2 completes, din_ready=0 and dout holds 0x0F. Raise dout_ready for one cycle -> dout=0xF0 next cycle; din_ready=1 one cycle later.
4. Send 3 bits, then a bit with sof=1 and value 1, then 7 bits of 0 -> frame_err pulses once; sel reads 1 after the sof bit; final dout=8'h01.
5. Assert rst after 5 bits of a word, then send a full 0x81 -> no word is emitted for the partial bits; dout=0x81; sel=0 right after reset.
6. din_valid toggled every other cycle with sof=1 on idle cycles, sending 0xC3 -> sof on idle cycles is ignored; dout=0xC3; no frame_err.
